// File: rtl/mem_bus_pkg.sv
// Shared types and default sizes for the memory bus responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2,
    WACK  = 2'd3
  } mem_bus_state_t;

  localparam int MEM_ADDR_W     = 8;
  localparam int MEM_DATA_W     = 8;
  localparam int MEM_RD_LAT_MAX = 15;

endpackage

// File: rtl/mem_bus_array.sv
// Single-port storage: synchronous write, asynchronous read on the same address.
module mem_bus_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Commit a write word at the clock edge; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_bus_slave.sv
// Memory-side responder on the shared rd/wrt/add/dat bus with programmable read latency.
//
// Bus handshake: rd or wrt is sampled only at a posedge while the block is IDLE
// (busy low and not in the write-ack cycle); a sampled request is accepted on
// that edge. rdy is a one-cycle completion pulse: for a read, dat carries the
// word during exactly the rdy cycle; for a write, the word was committed at the
// accept edge. rd and wrt together are refused with a one-cycle err pulse.
module mem_bus_slave
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wrt,
  input  logic [ADDR_W-1:0]     add,
  inout  wire logic [DATA_W-1:0] dat,
  output logic                  rdy,
  output logic                  busy,
  output logic                  err,
  output mem_bus_state_t        dbg_state_o
);

  localparam int CNT_W = $clog2(MEM_RD_LAT_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

  if (RD_LAT < 1 || RD_LAT > MEM_RD_LAT_MAX) begin : g_bad_lat
    $fatal(1, "mem_bus_slave: RD_LAT out of range 1..15");
  end

  mem_bus_state_t    state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rdy_q;
  logic              busy_q;
  logic              err_q;
  logic              oe_q;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_rdata;

  // A write commits at the accept edge itself; a reset on that edge drops it.
  assign arr_we   = (state_q == IDLE) && wrt && !rd && !rst;
  // The live bus address is only used at the accept edge; reads use the latched copy.
  assign arr_addr = (state_q == IDLE) ? add : addr_q;

  mem_bus_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (dat),
    .rdata (arr_rdata)
  );

  // Access sequencer: all outputs, including the dat enable, are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      oe_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd && wrt) begin
            err_q <= 1'b1;
          end else if (wrt) begin
            state_q <= WACK;
            rdy_q   <= 1'b1;
          end else if (rd) begin
            addr_q <= add;
            busy_q <= 1'b1;
            if (RD_LAT == 1) begin
              state_q <= DRIVE;
              rdy_q   <= 1'b1;
              oe_q    <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          busy_q <= 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DRIVE;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            oe_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DRIVE: state_q <= IDLE;
        WACK:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdy         = rdy_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;
  assign dat         = oe_q ? arr_rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_slave.sv
// Bench for mem_bus_slave: three instances (RD_LAT 2, 1, 15) on separate pulled-up buses,
// a timeline model of expected outputs, and directed scenarios with literal checks.
module tb_mem_bus_slave;
  import mem_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- buses ----------------
  logic           rd_s  [3];
  logic           wrt_s [3];
  logic [7:0]     add_s [3];
  logic [7:0]     wd_s  [3];
  logic           oe_s  [3];
  logic           rdy_s [3];
  logic           busy_s[3];
  logic           err_s [3];
  mem_bus_state_t dbg_s [3];

  tri1 [7:0] dat0, dat1, dat2;
  assign dat0 = oe_s[0] ? wd_s[0] : 8'hzz;
  assign dat1 = oe_s[1] ? wd_s[1] : 8'hzz;
  assign dat2 = oe_s[2] ? wd_s[2] : 8'hzz;
  wire [7:0] dat_w [3];
  assign dat_w[0] = dat0;
  assign dat_w[1] = dat1;
  assign dat_w[2] = dat2;

  int lat_of [3] = '{2, 1, 15};

  mem_bus_slave #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .rd(rd_s[0]), .wrt(wrt_s[0]), .add(add_s[0]), .dat(dat0),
    .rdy(rdy_s[0]), .busy(busy_s[0]), .err(err_s[0]), .dbg_state_o(dbg_s[0]));
  mem_bus_slave #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .rd(rd_s[1]), .wrt(wrt_s[1]), .add(add_s[1]), .dat(dat1),
    .rdy(rdy_s[1]), .busy(busy_s[1]), .err(err_s[1]), .dbg_state_o(dbg_s[1]));
  mem_bus_slave #(.ADDR_W(8), .DATA_W(8), .RD_LAT(15)) u_lat15 (
    .clk(clk), .rst(rst), .rd(rd_s[2]), .wrt(wrt_s[2]), .add(add_s[2]), .dat(dat2),
    .rdy(rdy_s[2]), .busy(busy_s[2]), .err(err_s[2]), .dbg_state_o(dbg_s[2]));

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, int i, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Edge-indexed timeline: an access accepted at edge e fixes which intervals
  // (the time after edge k) show busy, rdy, data or err.
  int         cyc = 0;
  bit         chk_en = 1'b0;
  int         next_acc [3];
  int         acc_edge [3];
  int         drv_edge [3];
  bit         rd_pend  [3];
  logic [7:0] rd_val   [3];
  bit         rd_known [3];
  int         wack_edge[3];
  int         err_edge [3];
  logic [7:0] mem_m [3][256];
  bit         known [3][256];

  initial begin
    for (int i = 0; i < 3; i++) begin
      next_acc[i] = 0; acc_edge[i] = -10; drv_edge[i] = -10; rd_pend[i] = 1'b0;
      rd_val[i] = 8'h00; rd_known[i] = 1'b0; wack_edge[i] = -10; err_edge[i] = -10;
      for (int a = 0; a < 256; a++) begin
        known[i][a] = 1'b0;
        mem_m[i][a] = 8'h00;
      end
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rd_pend[i]   = 1'b0;
        wack_edge[i] = -10;
        err_edge[i]  = -10;
        next_acc[i]  = cyc + 1;
      end else if (cyc >= next_acc[i]) begin
        if (rd_s[i] && wrt_s[i]) begin
          err_edge[i] = cyc;
          next_acc[i] = cyc + 1;
        end else if (wrt_s[i]) begin
          mem_m[i][add_s[i]] = dat_w[i];
          known[i][add_s[i]] = 1'b1;
          wack_edge[i] = cyc;
          next_acc[i]  = cyc + 2;
        end else if (rd_s[i]) begin
          rd_pend[i]  = 1'b1;
          rd_val[i]   = mem_m[i][add_s[i]];
          rd_known[i] = known[i][add_s[i]];
          acc_edge[i] = cyc;
          drv_edge[i] = cyc + lat_of[i] - 1;
          next_acc[i] = cyc + lat_of[i] + 1;
        end
      end
    end
  end

  // Compare every instance every cycle, away from the active edge.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        bit drive_e, busy_e, rdy_e, err_e, wack_e;
        mem_bus_state_t st_e;
        drive_e = rd_pend[i] && (cyc == drv_edge[i]);
        busy_e  = rd_pend[i] && (cyc >= acc_edge[i]) && (cyc <= drv_edge[i]);
        wack_e  = (cyc == wack_edge[i]);
        rdy_e   = drive_e || wack_e;
        err_e   = (cyc == err_edge[i]);
        if (drive_e)      st_e = DRIVE;
        else if (busy_e)  st_e = WAIT;
        else if (wack_e)  st_e = WACK;
        else              st_e = IDLE;
        chk("m_rdy",  i, int'(rdy_s[i]),  int'(rdy_e));
        chk("m_busy", i, int'(busy_s[i]), int'(busy_e));
        chk("m_err",  i, int'(err_s[i]),  int'(err_e));
        chk("m_state", i, int'(dbg_s[i]), int'(st_e));
        if (drive_e) begin
          if (rd_known[i]) chk("m_dat", i, int'(dat_w[i]), int'(rd_val[i]));
        end else if (!oe_s[i]) begin
          chk("m_dat_released", i, int'(dat_w[i]), 'hFF);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_op(int i, logic [7:0] a, logic [7:0] d);
    @(negedge clk);
    rd_s[i] = 1'b0; wrt_s[i] = 1'b1; add_s[i] = a; wd_s[i] = d; oe_s[i] = 1'b1;
    @(negedge clk);
    wrt_s[i] = 1'b0; oe_s[i] = 1'b0;
    chk("wr_rdy", i, int'(rdy_s[i]), 1);
    chk("wr_busy", i, int'(busy_s[i]), 0);
  endtask

  task automatic read_op(int i, logic [7:0] a, logic [7:0] exp);
    @(negedge clk);
    rd_s[i] = 1'b1; wrt_s[i] = 1'b0; add_s[i] = a;
    for (int k = 1; k <= lat_of[i]; k++) begin
      @(negedge clk);
      rd_s[i] = 1'b0;
      if (k < lat_of[i]) begin
        chk("rd_wait_rdy", i, int'(rdy_s[i]), 0);
        chk("rd_wait_busy", i, int'(busy_s[i]), 1);
      end else begin
        chk("rd_rdy", i, int'(rdy_s[i]), 1);
        chk("rd_dat", i, int'(dat_w[i]), int'(exp));
      end
    end
    @(negedge clk);
    chk("rd_after_rdy", i, int'(rdy_s[i]), 0);
  endtask

  logic [7:0] bb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      rd_s[i] = 1'b0; wrt_s[i] = 1'b0; add_s[i] = 8'h00; wd_s[i] = 8'h00; oe_s[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdy", i, int'(rdy_s[i]), 0);
      chk("rst_busy", i, int'(busy_s[i]), 0);
      chk("rst_err", i, int'(err_s[i]), 0);
      chk("rst_dat", i, int'(dat_w[i]), 'hFF);
    end
    rst = 1'b0;

    // Write then read back with latency 2.
    write_op(0, 8'h10, 8'hA5);
    read_op(0, 8'h10, 8'hA5);

    // Simultaneous rd and wrt: refused, memory unchanged.
    write_op(0, 8'h20, 8'h00);
    @(negedge clk);
    rd_s[0] = 1'b1; wrt_s[0] = 1'b1; add_s[0] = 8'h20; wd_s[0] = 8'h77; oe_s[0] = 1'b1;
    @(negedge clk);
    rd_s[0] = 1'b0; wrt_s[0] = 1'b0; oe_s[0] = 1'b0;
    chk("conflict_err", 0, int'(err_s[0]), 1);
    chk("conflict_rdy", 0, int'(rdy_s[0]), 0);
    @(negedge clk);
    chk("conflict_err_pulse", 0, int'(err_s[0]), 0);
    read_op(0, 8'h20, 8'h00);

    // Back-to-back reads with rd held high.
    for (int j = 0; j < 4; j++) write_op(0, 8'(j), bb[j]);
    @(negedge clk);
    rd_s[0] = 1'b1; add_s[0] = 8'h00;
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk);
        if (k < 2) begin
          chk("b2b_wait_rdy", 0, int'(rdy_s[0]), 0);
        end else begin
          chk("b2b_rdy", 0, int'(rdy_s[0]), 1);
          chk("b2b_dat", 0, int'(dat_w[0]), int'(bb[j]));
          if (j < 3) add_s[0] = 8'(j + 1);
          else       rd_s[0] = 1'b0;
        end
      end
      if (j < 3) begin
        @(negedge clk);
        chk("b2b_gap_busy", 0, int'(busy_s[0]), 0);
        @(posedge clk);
      end
    end

    // Reset during the wait of a read of 8'hFF.
    write_op(0, 8'hFF, 8'hC3);
    @(negedge clk);
    rd_s[0] = 1'b1; add_s[0] = 8'hFF;
    @(negedge clk);
    rd_s[0] = 1'b0;
    chk("rstmid_busy_before", 0, int'(busy_s[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_rdy", 0, int'(rdy_s[0]), 0);
    chk("rstmid_busy", 0, int'(busy_s[0]), 0);
    chk("rstmid_dat", 0, int'(dat_w[0]), 'hFF);
    read_op(0, 8'hFF, 8'hC3);

    // Address change during wait is ignored.
    write_op(0, 8'h30, 8'h99);
    @(negedge clk);
    rd_s[0] = 1'b1; add_s[0] = 8'h10;
    @(negedge clk);
    rd_s[0] = 1'b0; add_s[0] = 8'h30;
    @(negedge clk);
    chk("addrchg_rdy", 0, int'(rdy_s[0]), 1);
    chk("addrchg_dat", 0, int'(dat_w[0]), 'hA5);

    // Latency extremes, address boundaries.
    write_op(1, 8'hFF, 8'h3C);
    write_op(1, 8'h00, 8'hC0);
    read_op(1, 8'hFF, 8'h3C);
    read_op(1, 8'h00, 8'hC0);
    write_op(2, 8'hFF, 8'h5A);
    write_op(2, 8'h00, 8'hA6);
    read_op(2, 8'hFF, 8'h5A);
    read_op(2, 8'h00, 8'hA6);

    // Reset on a write accept edge drops the write.
    write_op(1, 8'h40, 8'h12);
    @(negedge clk);
    wrt_s[1] = 1'b1; add_s[1] = 8'h40; wd_s[1] = 8'h99; oe_s[1] = 1'b1; rst = 1'b1;
    @(negedge clk);
    wrt_s[1] = 1'b0; oe_s[1] = 1'b0; rst = 1'b0;
    chk("rstwr_rdy", 1, int'(rdy_s[1]), 0);
    read_op(1, 8'h40, 8'h12);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
